multi_sensor_fusion_top: RTL and testbench

Frame-level fusion core that sits after the sensor front-ends and feeds the perception back-end. It accepts one camera, LiDAR, radar and IMU word set plus a timestamp, and validates each sensor header. It builds a 96-element feature vector, applies per-group attention gating and value scaling, then runs a 128×96 fully-connected layer. The result is a clamped 128×16-bit fused tensor with sticky per-frame error flags.

---
 rtl/fusion_pkg.sv | 36 +++
 rtl/fusion_fc_row.sv | 32 +++
 rtl/multi_sensor_fusion_top.sv | 188 ++++++++++++++++++
 tb/tb_multi_sensor_fusion_top.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fusion_pkg.sv
// Shared types, sizes and error-bit positions for the multi-sensor fusion core.
package fusion_pkg;

    typedef logic signed [15:0] elem_t;

    typedef enum logic [1:0] {
        IDLE,
        ATTN,
        FC,
        DONE
    } state_t;

    localparam int N_GRP   = 6;
    localparam int GRP_LEN = 16;
    localparam int N_FEAT  = 96;
    localparam int N_OUT   = 128;
    localparam int SHIFT   = 8;

    localparam int ERR_NAL   = 0;
    localparam int ERR_DIM   = 1;
    localparam int ERR_LIDAR = 2;
    localparam int ERR_RADAR = 3;
    localparam int ERR_IMU   = 4;
    localparam int ERR_TS    = 5;

    function automatic elem_t sat16(input logic signed [31:0] val);
        if (val > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (val < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return val[15:0];
        end
    endfunction

endpackage

// File: rtl/fusion_fc_row.sv
// One fully-connected output row: 96-term dot product, bias, arithmetic shift and clamp.
module fusion_fc_row
    import fusion_pkg::*;
#(
    parameter int MIN_VAL = -16384,
    parameter int MAX_VAL = 16383
) (
    input  logic [N_FEAT-1:0][15:0] i_weights,
    input  logic [N_FEAT-1:0][15:0] i_v,
    input  logic [15:0]             i_bias,
    output logic [15:0]             o_y
);

    logic signed [47:0] w_acc;
    logic signed [47:0] w_shifted;

    always_comb begin
        w_acc = 48'($signed(i_bias)) <<< SHIFT;
        for (int j = 0; j < N_FEAT; j++) begin
            w_acc = w_acc + 48'($signed(i_weights[j]) * $signed(i_v[j]));
        end
        w_shifted = w_acc >>> SHIFT;
        if (w_shifted > 48'(MAX_VAL)) begin
            o_y = 16'(MAX_VAL);
        end else if (w_shifted < 48'(MIN_VAL)) begin
            o_y = 16'(MIN_VAL);
        end else begin
            o_y = w_shifted[15:0];
        end
    end

endmodule

// File: rtl/multi_sensor_fusion_top.sv
// Frame-level multi-sensor fusion: header checks, per-group attention gating, 128x96 FC layer.
// Define FUSION_TS_CHECK_EN to flag non-increasing frame timestamps (error bit 5).
module multi_sensor_fusion_top
    import fusion_pkg::*;
#(
    parameter int CAMERA_WIDTH   = 3072,
    parameter int LIDAR_WIDTH    = 512,
    parameter int RADAR_WIDTH    = 128,
    parameter int IMU_WIDTH      = 64,
    parameter int OUTPUT_WIDTH   = 2048,
    parameter int FUSION_MIN_VAL = -16384,
    parameter int FUSION_MAX_VAL = 16383
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CAMERA_WIDTH-1:0]             camera_bitstream,
    input  logic                                camera_valid,
    input  logic [LIDAR_WIDTH-1:0]              lidar_compressed,
    input  logic                                lidar_valid,
    input  logic [RADAR_WIDTH-1:0]              radar_raw,
    input  logic                                radar_valid,
    input  logic [IMU_WIDTH-1:0]                imu_raw,
    input  logic                                imu_valid,
    input  logic [63:0]                         timestamp,
    input  logic [N_GRP-1:0][GRP_LEN-1:0][15:0] W_q,
    input  logic [N_GRP-1:0][GRP_LEN-1:0][15:0] W_k,
    input  logic [N_GRP-1:0][GRP_LEN-1:0][15:0] W_v,
    input  logic [N_OUT-1:0][N_FEAT-1:0][15:0]  fc_weights,
    input  logic [N_OUT-1:0][15:0]              fc_bias,
    output logic [OUTPUT_WIDTH-1:0]             fused_tensor,
    output logic                                output_valid,
    output logic [7:0]                          error_flags
);

    state_t                  r_state, w_state_next;
    logic [N_FEAT-1:0][15:0] r_x, w_x, r_v, w_v_gated;
    logic [N_OUT-1:0][15:0]  r_fused;
    logic [6:0]              r_row;
    logic [7:0]              r_err, w_err;
    logic                    r_out_valid, w_accept, w_last_row, w_ts_err;
    logic [N_GRP-1:0]        w_keep;
    logic [15:0]             w_y;
    logic                    w_unused_camera;

    assign w_accept   = (r_state == IDLE) & camera_valid & lidar_valid & radar_valid & imu_valid;
    assign w_last_row = (r_row == 7'(N_OUT - 1));
    // Camera payload between the 512-bit feature window and the 32-bit size header is not fused.
    assign w_unused_camera = ^camera_bitstream[CAMERA_WIDTH-33:512];

`ifdef FUSION_TS_CHECK_EN
    logic [63:0] r_ts_prev;
    logic        r_have_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts_prev   <= '0;
            r_have_prev <= 1'b0;
        end else if (w_accept) begin
            r_ts_prev   <= timestamp;
            r_have_prev <= 1'b1;
        end
    end

    assign w_ts_err = r_have_prev & (timestamp <= r_ts_prev);
`else
    assign w_ts_err = 1'b0;
`endif

    always_comb begin
        w_err            = '0;
        w_err[ERR_NAL]   = (camera_bitstream[31:0] == 32'h0);
        w_err[ERR_DIM]   = (camera_bitstream[CAMERA_WIDTH-1 -: 16] > 16'd4096) ||
                           (camera_bitstream[CAMERA_WIDTH-17 -: 16] > 16'd4096);
        w_err[ERR_LIDAR] = (lidar_compressed[LIDAR_WIDTH-1 -: 32] != 32'h0) &&
                           (lidar_compressed[LIDAR_WIDTH-1 -: 32] != 32'h4C494441);
        w_err[ERR_RADAR] = radar_raw[RADAR_WIDTH-1];
        w_err[ERR_IMU]   = (imu_raw[31:16] == 16'h0);
        w_err[ERR_TS]    = w_ts_err;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_FEAT; gi++) begin : g_feat
            logic signed [31:0] w_prod;
            if (gi < 32) begin : g_cam
                assign w_x[gi] = camera_bitstream[16*gi +: 16];
            end else if (gi < 64) begin : g_lidar
                assign w_x[gi] = lidar_compressed[16*(gi-32) +: 16];
            end else if (gi < 72) begin : g_radar
                assign w_x[gi] = radar_raw[16*(gi-64) +: 16];
            end else if (gi < 76) begin : g_imu
                assign w_x[gi] = imu_raw[16*(gi-72) +: 16];
            end else if (gi >= 80 && gi < 84) begin : g_ts
                assign w_x[gi] = timestamp[16*(gi-80) +: 16];
            end else begin : g_pad
                assign w_x[gi] = '0;
            end
            assign w_prod        = $signed(W_v[gi/GRP_LEN][gi%GRP_LEN]) * $signed(r_x[gi]);
            assign w_v_gated[gi] = w_keep[gi/GRP_LEN] ? sat16(w_prod >>> SHIFT) : 16'h0;
        end

        for (gi = 0; gi < N_GRP; gi++) begin : g_grp
            logic signed [39:0] w_q_sum, w_k_sum;
            always_comb begin
                w_q_sum = '0;
                w_k_sum = '0;
                for (int e = 0; e < GRP_LEN; e++) begin
                    w_q_sum = w_q_sum + 40'($signed(W_q[gi][e]) * $signed(r_x[gi*GRP_LEN+e]));
                    w_k_sum = w_k_sum + 40'($signed(W_k[gi][e]) * $signed(r_x[gi*GRP_LEN+e]));
                end
            end
            assign w_keep[gi] = (w_q_sum[39] == w_k_sum[39]);
        end
    endgenerate

    fusion_fc_row #(
        .MIN_VAL(FUSION_MIN_VAL),
        .MAX_VAL(FUSION_MAX_VAL)
    ) u_fc_row (
        .i_weights(fc_weights[r_row]),
        .i_v      (r_v),
        .i_bias   (fc_bias[r_row]),
        .o_y      (w_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = ATTN;
            ATTN:    w_state_next = (r_err != 8'h0) ? DONE : FC;
            FC:      if (w_last_row) w_state_next = DONE;
            DONE:    if (!(camera_valid & lidar_valid & radar_valid & imu_valid)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // output_valid is held from entry into DONE until the next frame is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x         <= '0;
            r_v         <= '0;
            r_fused     <= '0;
            r_err       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x         <= w_x;
                        r_err       <= w_err;
                        r_fused     <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                ATTN: begin
                    r_row <= '0;
                    if (r_err != 8'h0) begin
                        r_out_valid <= 1'b1;
                    end else begin
                        r_v <= w_v_gated;
                    end
                end
                FC: begin
                    r_fused[r_row] <= w_y;
                    r_row          <= r_row + 7'd1;
                    if (w_last_row) begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fused_tensor = r_fused;
    assign output_valid = r_out_valid;
    assign error_flags  = r_err;

endmodule

// File: tb/tb_multi_sensor_fusion_top.sv
// Scoreboard bench for multi_sensor_fusion_top: directed frames push expectations, a monitor checks them.
module tb_multi_sensor_fusion_top;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [3071:0]                camera_bitstream;
    logic                         camera_valid;
    logic [511:0]                 lidar_compressed;
    logic                         lidar_valid;
    logic [127:0]                 radar_raw;
    logic                         radar_valid;
    logic [63:0]                  imu_raw;
    logic                         imu_valid;
    logic [63:0]                  timestamp;
    logic [5:0][15:0][15:0]       W_q, W_k, W_v;
    logic [127:0][95:0][15:0]     fc_weights;
    logic [127:0][15:0]           fc_bias;
    logic [2047:0]                fused_tensor;
    logic                         output_valid;
    logic [7:0]                   error_flags;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    typedef struct {
        string         name;
        logic [7:0]    flags;
        logic [2047:0] tensor;
        int            lat;
        longint        acc;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [3071:0] CAM_CLEAN = 3072'h123456789ABCDEF;
    localparam logic [511:0]  LID_CLEAN = 512'h87654321;
    localparam logic [127:0]  RAD_CLEAN = 128'h12345678;
    localparam logic [63:0]   IMU_CLEAN = 64'hCAFEBABE;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_sensor_fusion_top dut (
        .clk             (clk),
        .rst             (rst),
        .camera_bitstream(camera_bitstream),
        .camera_valid    (camera_valid),
        .lidar_compressed(lidar_compressed),
        .lidar_valid     (lidar_valid),
        .radar_raw       (radar_raw),
        .radar_valid     (radar_valid),
        .imu_raw         (imu_raw),
        .imu_valid       (imu_valid),
        .timestamp       (timestamp),
        .W_q             (W_q),
        .W_k             (W_k),
        .W_v             (W_v),
        .fc_weights      (fc_weights),
        .fc_bias         (fc_bias),
        .fused_tensor    (fused_tensor),
        .output_valid    (output_valid),
        .error_flags     (error_flags)
    );

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic set_valids(input logic v);
        camera_valid = v;
        lidar_valid  = v;
        radar_valid  = v;
        imu_valid    = v;
    endtask

    // mode 0: all weights zero; 1: group-0 attention kept; 2: group-0 attention gated off
    task automatic set_weights(input int mode);
        W_q        = '0;
        W_k        = '0;
        W_v        = '0;
        fc_weights = '0;
        if (mode != 0) begin
            W_v[0][0] = 16'd256;
            W_v[0][1] = 16'h7FFF;
            W_q[0][0] = 16'd1;
            W_k[0][0] = (mode == 2) ? 16'hFFFF : 16'd1;
            for (int i = 0; i < 128; i++) begin
                fc_weights[i][0] = 16'(i);
                fc_weights[i][1] = 16'd1;
            end
        end
    endtask

    task automatic set_bias(input bit use_index, input logic [15:0] val);
        for (int i = 0; i < 128; i++) fc_bias[i] = use_index ? 16'(i) : val;
    endtask

    // kind 1: element i = i; 2: every element = kval; 3: element i = 2i+127
    task automatic send_frame(input string name, input logic [3071:0] cam, input logic [511:0] lid,
                              input logic [127:0] rad, input logic [63:0] imu, input logic [63:0] ts,
                              input logic [7:0] exp_flags, input int kind, input logic [15:0] kval);
        exp_t e;
        int   waited;
        @(negedge clk);
        camera_bitstream = cam;
        lidar_compressed = lid;
        radar_raw        = rad;
        imu_raw          = imu;
        timestamp        = ts;
        set_valids(1'b1);
        @(posedge clk);
        #1;
        e.name   = name;
        e.acc    = cyc;
        e.flags  = exp_flags;
        e.lat    = (exp_flags != 8'h0) ? 1 : 129;
        e.tensor = '0;
        if (exp_flags == 8'h0) begin
            for (int i = 0; i < 128; i++) begin
                case (kind)
                    1:       e.tensor[16*i +: 16] = 16'(i);
                    2:       e.tensor[16*i +: 16] = kval;
                    3:       e.tensor[16*i +: 16] = 16'(2 * i + 127);
                    default: e.tensor[16*i +: 16] = 16'h0;
                endcase
            end
        end
        sb_q.push_back(e);
        waited = 0;
        while (!output_valid && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!output_valid) begin
            total++;
            bad++;
            $display("FAIL %s timeout: output_valid=%0b after %0d cycles, want 1", name, output_valid, waited);
            sb_q.delete();
        end
        @(negedge clk);
        set_valids(1'b0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: on each rising output_valid, pop and compare one expected frame.
    initial begin
        exp_t   e;
        logic   prev_ov;
        int     idx;
        longint lat;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (output_valid === 1'b1 && prev_ov !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: output_valid=1 with no frame pending, want 0");
                end else begin
                    e   = sb_q.pop_front();
                    lat = cyc - e.acc;
                    $display("txn %s: flags=%02h lat=%0d elem0=%04h elem127=%04h",
                             e.name, error_flags, lat, fused_tensor[15:0], fused_tensor[2047:2032]);
                    total++;
                    if (error_flags !== e.flags) begin
                        bad++;
                        $display("FAIL %s flags: got %02h want %02h", e.name, error_flags, e.flags);
                    end
                    total++;
                    if (lat != longint'(e.lat)) begin
                        bad++;
                        $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat);
                    end
                    total++;
                    if (fused_tensor !== e.tensor) begin
                        bad++;
                        idx = 0;
                        for (int i = 127; i >= 0; i--) begin
                            if (fused_tensor[16*i +: 16] !== e.tensor[16*i +: 16]) idx = i;
                        end
                        $display("FAIL %s tensor: elem %0d got %04h want %04h", e.name, idx,
                                 fused_tensor[16*idx +: 16], e.tensor[16*idx +: 16]);
                    end
                end
            end
            prev_ov = output_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3071:0] cam_dim;
        logic [511:0]  lid_bad, lid_ok;
        logic [127:0]  rad_ovf;
        logic [63:0]   ts;

        rst = 1'b1;
        set_valids(1'b0);
        camera_bitstream = '0;
        lidar_compressed = '0;
        radar_raw        = '0;
        imu_raw          = '0;
        timestamp        = '0;
        set_weights(0);
        set_bias(1'b1, 16'h0);
        repeat (3) @(negedge clk);
        check_val("reset_output_valid", {63'b0, output_valid}, 64'd0);
        check_val("reset_error_flags", {56'b0, error_flags}, 64'd0);
        check_val("reset_tensor_nonzero", {63'b0, |fused_tensor}, 64'd0);
        rst = 1'b0;

        cam_dim = '0;
        cam_dim[3071:3040] = 32'h2000_2000;
        lid_bad = LID_CLEAN;
        lid_bad[511:480] = 32'h12345678;
        lid_ok = LID_CLEAN;
        lid_ok[511:480] = 32'h4C494441;
        rad_ovf = RAD_CLEAN;
        rad_ovf[127:96] = 32'hFFFFFFFF;
        ts = 64'd1000;

        send_frame("clean", CAM_CLEAN, LID_CLEAN, RAD_CLEAN, IMU_CLEAN, ts, 8'h00, 1, 16'h0);
        send_frame("cam_zero", '0, LID_CLEAN, RAD_CLEAN, IMU_CLEAN, ts + 1, 8'h01, 0, 16'h0);
        send_frame("cam_dims", cam_dim, LID_CLEAN, RAD_CLEAN, IMU_CLEAN, ts + 2, 8'h03, 0, 16'h0);
        send_frame("lidar_bad_magic", CAM_CLEAN, lid_bad, RAD_CLEAN, IMU_CLEAN, ts + 3, 8'h04, 0, 16'h0);
        send_frame("lidar_good_magic", CAM_CLEAN, lid_ok, RAD_CLEAN, IMU_CLEAN, ts + 4, 8'h00, 1, 16'h0);
        send_frame("radar_overflow", CAM_CLEAN, LID_CLEAN, rad_ovf, IMU_CLEAN, ts + 5, 8'h08, 0, 16'h0);
        set_bias(1'b0, 16'h7FFF);
        send_frame("clamp_high", CAM_CLEAN, LID_CLEAN, RAD_CLEAN, IMU_CLEAN, ts + 6, 8'h00, 2, 16'h3FFF);
        set_bias(1'b0, 16'h8000);
        send_frame("clamp_low", CAM_CLEAN, LID_CLEAN, RAD_CLEAN, IMU_CLEAN, ts + 7, 8'h00, 2, 16'hC000);
        set_bias(1'b1, 16'h0);
        send_frame("imu_sync_loss", CAM_CLEAN, LID_CLEAN, RAD_CLEAN, 64'h1, ts + 8, 8'h10, 0, 16'h0);
        send_frame("imu_ok", CAM_CLEAN, LID_CLEAN, RAD_CLEAN, 64'h80008000, ts + 9, 8'h00, 1, 16'h0);
        set_weights(1);
        send_frame("attn_kept", 3072'h7FFF0100, LID_CLEAN, RAD_CLEAN, IMU_CLEAN, ts + 10, 8'h00, 3, 16'h0);
        set_weights(2);
        send_frame("attn_gated", 3072'h7FFF0100, LID_CLEAN, RAD_CLEAN, IMU_CLEAN, ts + 11, 8'h00, 1, 16'h0);
        set_weights(0);
`ifdef FUSION_TS_CHECK_EN
        send_frame("ts_repeat", CAM_CLEAN, LID_CLEAN, RAD_CLEAN, IMU_CLEAN, ts + 11, 8'h20, 0, 16'h0);
`endif

        // Abort a clean frame once rows 0..49 are written and the row counter sits at 50.
        @(negedge clk);
        camera_bitstream = CAM_CLEAN;
        lidar_compressed = LID_CLEAN;
        radar_raw        = RAD_CLEAN;
        imu_raw          = IMU_CLEAN;
        timestamp        = ts + 20;
        set_valids(1'b1);
        @(posedge clk);
        repeat (51) @(posedge clk);
        @(negedge clk);
        check_val("midframe_row49", {48'b0, fused_tensor[49*16 +: 16]}, 64'd49);
        check_val("midframe_valid_low", {63'b0, output_valid}, 64'd0);
        rst = 1'b1;
        set_valids(1'b0);
        @(posedge clk);
        #1;
        check_val("abort_output_valid", {63'b0, output_valid}, 64'd0);
        check_val("abort_error_flags", {56'b0, error_flags}, 64'd0);
        check_val("abort_tensor_nonzero", {63'b0, |fused_tensor}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send_frame("post_reset_clean", CAM_CLEAN, LID_CLEAN, RAD_CLEAN, IMU_CLEAN, 64'd5, 8'h00, 1, 16'h0);

        repeat (3) @(negedge clk);
        check_val("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
